lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencing controller between execute-stage address generation and the single-port data-memory bus. It takes one load or store per request and checks funct3 and alignment. It drives a req/gnt/rvalid memory handshake with byte enables, extracts and sign- or zero-extends load data, and holds `stall_o` high until the access retires. Only one access is in flight at a time.

## Interface
- No parameters. Data width is fixed at 32 bits; memory is byte-addressed with word-aligned bus addresses.
- `clk_i` in 1: single clock, all state on the rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: execute requests an access; held stable while `stall_o`=1.
- `is_store_i` in 1: 1=store (SB/SH/SW), 0=load.
- `funct3_i` in 3: RV32I width/sign code.
- `addr_i` in 32: effective address (rs1 + sext(imm)).
- `store_data_i` in 32: rs2 value.
- `rd_i` in 5: load destination register.
- `stall_o` out 1: pipeline hold.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: 1=write.
- `mem_addr_o` out 32: `{addr[31:2],2'b00}`.
- `mem_be_o` out 4: byte enables.
- `mem_wdata_o` out 32: lane-replicated store data.
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_rvalid_i` in 1: read data valid.
- `mem_rdata_i` in 32: read word.
- `wb_valid_o` out 1: one-cycle load writeback pulse.
- `wb_rd_o` out 5: destination register for the writeback.
- `wb_data_o` out 32: extended load data.
- `done_o` out 1: one-cycle retire pulse for any access, including faulted ones.
- `misalign_o` out 1: one-cycle misaligned-access fault pulse.
- `illegal_o` out 1: one-cycle illegal-funct3 pulse.

## Operation
- FSM states are IDLE, REQ, RESP and DONE.
- **IDLE**
  - On `req_valid_i`, latch `is_store`, `funct3`, `addr`, `store_data` and `rd`.
  - Illegal code (loads: 011, 110, 111; stores: funct3[2]=1 or 011) → DONE with `illegal_o`.
  - Misaligned access (half with addr[0]=1; word with addr[1:0]≠0) → DONE with `misalign_o`.
  - Otherwise → REQ.
- **REQ**
  - Drive `mem_req_o`=1 and all bus fields from latched values; hold them constant until `mem_gnt_i`.
  - On gnt: a store → DONE; a load → RESP.
- **RESP**
  - `mem_req_o`=0; wait for `mem_rvalid_i`.
  - On rvalid: latch the extracted data → DONE.
  - An rvalid arriving in the same cycle as gnt is not legal; the bus guarantees at least one cycle between them.
- **DONE**
  - Assert `done_o` for one cycle, plus `wb_valid_o` for a successful load and the latched fault pulse if any.
  - → IDLE unconditionally.
- **Byte enables**
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `4'b0011 << {addr[1],1'b0}`.
  - Word: `4'b1111`.
  - Loads use the same enables (`mem_we_o`=0).
- **Write data**
  - SB: `{4{d[7:0]}}`.
  - SH: `{2{d[15:0]}}`.
  - SW: `d`.
- **Load extract**
  - `sh = mem_rdata_i >> (8*addr[1:0])`.
  - LB: sext `sh[7:0]`; LBU: zext `sh[7:0]`.
  - LH: sext `sh[15:0]`; LHU: zext `sh[15:0]`.
  - LW: `sh`.
- **Faults**: a faulted access never raises `mem_req_o`, and `wb_valid_o` stays 0.

## Timing
- **Reset** (asynchronous, any state):
  - FSM → IDLE.
  - `mem_req_o`, `mem_we_o`, `wb_valid_o`, `done_o`, `misalign_o`, `illegal_o` and `stall_o` = 0.
  - `mem_addr_o`, `mem_be_o`, `mem_wdata_o`, `wb_rd_o` and `wb_data_o` = 0.
  - Reset during REQ or RESP drops the request immediately; a late rvalid after reset is ignored in IDLE.
- **Stall**: `stall_o` = (IDLE && `req_valid_i`) || REQ || RESP. It is combinational and low in DONE, so the pipeline advances on the DONE cycle.
- **Latency**
  - Accept at cycle 0; `mem_req_o` high from cycle 1.
  - Store with gnt at cycle 1 → `done_o` at cycle 2.
  - Load with gnt at cycle 1 and rvalid at cycle 2 → `wb_valid_o`/`done_o` at cycle 3.
  - Fault → pulse at cycle 1, no bus activity.
- **Back-to-back**: `req_valid_i` in the DONE cycle is ignored; the next access is accepted in the following IDLE cycle.
- **Bus outputs**: registered (driven from latched fields), stable for every cycle of REQ.
- **Writeback outputs**: `wb_data_o`/`wb_rd_o` hold their value until the next load writeback.

## Test plan
- **LW, aligned**: addr=0x1000, gnt in cycle 1, rvalid in cycle 3 with rdata=0xDEADBEEF → `mem_addr_o`=0x1000, `mem_be_o`=1111; `wb_data_o`=0xDEADBEEF with `wb_rd_o`=rd; `stall_o` high for cycles 0–3 and low in DONE.
- **LB/LBU lane select**: addr=0x1003, rdata=0x80FF0000 → LB gives 0xFFFFFF80, LBU gives 0x00000080, `mem_be_o`=1000. LHU at addr=0x1002 gives 0x000080FF.
- **SB, delayed grant**: addr=0x2001, data=0x12345678, gnt delayed 3 cycles → `mem_be_o`=0010, `mem_wdata_o`=0x78787878 and `mem_we_o`=1, all held through the wait; `done_o` one cycle after gnt; no `wb_valid_o`.
- **Faults**
  - LW at addr=0x1002 → `misalign_o` and `done_o` in cycle 1, `mem_req_o` never high.
  - Load with funct3=3'b111 → `illegal_o` and `done_o` in cycle 1, `mem_req_o` never high.
- **Reset mid-access**: assert `rst_n_i` low in RESP, then drive rvalid → all outputs 0 immediately, no `wb_valid_o`; the next LW completes normally.
- **Back-to-back**: SW then LW with `req_valid_i` held high → the second access is accepted in the IDLE cycle after DONE, with no dropped or duplicated request.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencing controller: decodes one RV32I load/store at a time,
// runs the req/gnt/rvalid handshake and returns extended load data.
module lsu_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        done_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r;
  logic        is_store_r;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic [4:0]  rd_r;
  logic        illegal_s;
  logic        misalign_s;

  function automatic logic f3_illegal(input logic st, input logic [2:0] f3);
    logic bad;
    if (st) begin
      bad = f3[2] | (f3 == 3'b011);
    end else begin
      bad = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    end
    return bad;
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {lo, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b100:  res = {24'd0, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b101:  res = {16'd0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  assign illegal_s  = f3_illegal(is_store_i, funct3_i);
  assign misalign_s = addr_misaligned(funct3_i, addr_i[1:0]);

  // Pipeline hold: combinational so the pipeline advances in the DONE cycle.
  always_comb begin
    stall_o = 1'b0;
    case (state_r)
      ST_IDLE: stall_o = req_valid_i;
      ST_REQ:  stall_o = 1'b1;
      ST_RESP: stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  // Access sequencer with registered bus, writeback and pulse outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_IDLE;
      is_store_r  <= 1'b0;
      funct3_r    <= 3'b000;
      addr_lo_r   <= 2'b00;
      rd_r        <= 5'd0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_be_o    <= 4'd0;
      mem_wdata_o <= 32'd0;
      wb_valid_o  <= 1'b0;
      wb_rd_o     <= 5'd0;
      wb_data_o   <= 32'd0;
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid_i) begin
            is_store_r <= is_store_i;
            funct3_r   <= funct3_i;
            addr_lo_r  <= addr_i[1:0];
            rd_r       <= rd_i;
            if (illegal_s) begin
              state_r   <= ST_DONE;
              done_o    <= 1'b1;
              illegal_o <= 1'b1;
            end else if (misalign_s) begin
              state_r    <= ST_DONE;
              done_o     <= 1'b1;
              misalign_o <= 1'b1;
            end else begin
              state_r     <= ST_REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_store_i;
              mem_addr_o  <= {addr_i[31:2], 2'b00};
              mem_be_o    <= lane_be(funct3_i, addr_i[1:0]);
              mem_wdata_o <= lane_wdata(funct3_i, store_data_i);
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (is_store_r) begin
              state_r <= ST_DONE;
              done_o  <= 1'b1;
            end else begin
              state_r <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (mem_rvalid_i) begin
            state_r    <= ST_DONE;
            wb_data_o  <= load_extract(funct3_r, addr_lo_r, mem_rdata_i);
            wb_rd_o    <= rd_r;
            wb_valid_o <= 1'b1;
            done_o     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          wb_valid_o <= 1'b0;
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
          illegal_o  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          mem_req_o  <= 1'b0;
          mem_we_o   <= 1'b0;
          wb_valid_o <= 1'b0;
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
          illegal_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Table-driven bench for lsu_ctrl with a writeback scoreboard and
// hand-written reset and back-to-back sequences.
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        done_o;
  logic        misalign_o;
  logic        illegal_o;

  lsu_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_valid_i(req_valid_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i), .rd_i(rd_i),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .done_o(done_o), .misalign_o(misalign_o),
    .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_fault;  // 0 none, 1 misaligned, 2 illegal
    logic [31:0] exp_wb;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  vec_t vecs[14];
  wb_t  sb_q[$];
  wb_t  exp_e;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Writeback scoreboard: every wb pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (wb_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected no writeback", wb_rd_o, wb_data_o);
      end else begin
        exp_e = sb_q.pop_front();
        check("wb_rd", {27'd0, wb_rd_o}, {27'd0, exp_e.rd});
        check("wb_data", wb_data_o, exp_e.data);
      end
    end
  end

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    req_valid_i  = 1'b1;
    is_store_i   = st;
    funct3_i     = f3;
    addr_i       = a;
    store_data_i = d;
    rd_i         = rd;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk_i); #1;
    drive(v.is_store, v.f3, v.addr, v.sdata, v.rd);
    @(negedge clk_i);
    check("stall_accept", {31'd0, stall_o}, 32'd1);
    check("req_accept", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk_i); #1;
    if (v.exp_fault != 2'd0) begin
      req_valid_i = 1'b0;
      @(negedge clk_i);
      check("fault_done", {31'd0, done_o}, 32'd1);
      check("fault_misalign", {31'd0, misalign_o}, {31'd0, v.exp_fault == 2'd1});
      check("fault_illegal", {31'd0, illegal_o}, {31'd0, v.exp_fault == 2'd2});
      check("fault_no_req", {31'd0, mem_req_o}, 32'd0);
      check("fault_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("fault_done_clear", {31'd0, done_o}, 32'd0);
      check("fault_no_req_after", {31'd0, mem_req_o}, 32'd0);
      return;
    end
    for (int k = 0; k <= v.gnt_dly; k++) begin
      mem_gnt_i = (k == v.gnt_dly);
      if (!v.is_store && k == v.gnt_dly) sb_q.push_back('{v.rd, v.exp_wb});
      @(negedge clk_i);
      check("bus_req", {31'd0, mem_req_o}, 32'd1);
      check("bus_we", {31'd0, mem_we_o}, {31'd0, v.is_store});
      check("bus_addr", mem_addr_o, {v.addr[31:2], 2'b00});
      check("bus_be", {28'd0, mem_be_o}, {28'd0, v.exp_be});
      if (v.is_store) check("bus_wdata", mem_wdata_o, v.exp_wdata);
      check("req_stall", {31'd0, stall_o}, 32'd1);
      check("req_done", {31'd0, done_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    mem_gnt_i = 1'b0;
    if (!v.is_store) begin
      for (int k = 0; k <= v.rv_dly; k++) begin
        mem_rvalid_i = (k == v.rv_dly);
        mem_rdata_i  = (k == v.rv_dly) ? v.rdata : 32'h0BAD0BAD;
        @(negedge clk_i);
        check("resp_no_req", {31'd0, mem_req_o}, 32'd0);
        check("resp_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i); #1;
      end
      mem_rvalid_i = 1'b0;
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("done_pulse", {31'd0, done_o}, 32'd1);
    check("done_wb_valid", {31'd0, wb_valid_o}, {31'd0, !v.is_store});
    check("done_stall", {31'd0, stall_o}, 32'd0);
    check("done_no_req", {31'd0, mem_req_o}, 32'd0);
    check("done_no_fault", {30'd0, misalign_o, illegal_o}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'b010, 32'h1000, 32'h0, 5'd5,  32'hDEADBEEF, 0, 1, 4'b1111, 32'h0, 2'd0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h1003, 32'h0, 5'd6,  32'h80FF0000, 0, 0, 4'b1000, 32'h0, 2'd0, 32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h1003, 32'h0, 5'd7,  32'h80FF0000, 1, 0, 4'b1000, 32'h0, 2'd0, 32'h00000080};
    vecs[3]  = '{1'b0, 3'b101, 32'h1002, 32'h0, 5'd8,  32'h80FF0000, 0, 2, 4'b1100, 32'h0, 2'd0, 32'h000080FF};
    vecs[4]  = '{1'b0, 3'b001, 32'h1002, 32'h0, 5'd9,  32'h80FF0000, 0, 0, 4'b1100, 32'h0, 2'd0, 32'hFFFF80FF};
    vecs[5]  = '{1'b0, 3'b000, 32'h1001, 32'h0, 5'd10, 32'h00007F00, 0, 0, 4'b0010, 32'h0, 2'd0, 32'h0000007F};
    vecs[6]  = '{1'b1, 3'b000, 32'h2001, 32'h12345678, 5'd0, 32'h0, 3, 0, 4'b0010, 32'h78787878, 2'd0, 32'h0};
    vecs[7]  = '{1'b1, 3'b001, 32'h2002, 32'hCAFEBABE, 5'd0, 32'h0, 0, 0, 4'b1100, 32'hBABEBABE, 2'd0, 32'h0};
    vecs[8]  = '{1'b1, 3'b010, 32'h2004, 32'h0BADF00D, 5'd0, 32'h0, 1, 0, 4'b1111, 32'h0BADF00D, 2'd0, 32'h0};
    vecs[9]  = '{1'b0, 3'b010, 32'h1002, 32'h0, 5'd11, 32'h0, 0, 0, 4'b0000, 32'h0, 2'd1, 32'h0};
    vecs[10] = '{1'b0, 3'b111, 32'h1000, 32'h0, 5'd12, 32'h0, 0, 0, 4'b0000, 32'h0, 2'd2, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h2001, 32'h0, 5'd0,  32'h0, 0, 0, 4'b0000, 32'h0, 2'd1, 32'h0};
    vecs[12] = '{1'b1, 3'b100, 32'h2000, 32'h0, 5'd0,  32'h0, 0, 0, 4'b0000, 32'h0, 2'd2, 32'h0};
    vecs[13] = '{1'b0, 3'b001, 32'h1001, 32'h0, 5'd13, 32'h0, 0, 0, 4'b0000, 32'h0, 2'd1, 32'h0};

    rst_n_i = 1'b0;
    req_valid_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0;
    store_data_i = 32'h0; rd_i = 5'd0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    #12;
    check("rst_ctrl", {25'd0, stall_o, mem_req_o, mem_we_o, wb_valid_o, done_o, misalign_o, illegal_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_be_rd", {23'd0, mem_be_o, wb_rd_o}, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check("rst_wbdata", wb_data_o, 32'h0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Reset while waiting for read data, then a late rvalid in IDLE.
    @(posedge clk_i); #1;
    drive(1'b0, 3'b010, 32'h1000, 32'h0, 5'd7);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    req_valid_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check("midrst_ctrl", {25'd0, stall_o, mem_req_o, mem_we_o, wb_valid_o, done_o, misalign_o, illegal_o}, 32'd0);
    check("midrst_addr", mem_addr_o, 32'h0);
    check("midrst_be_rd", {23'd0, mem_be_o, wb_rd_o}, 32'd0);
    check("midrst_wbdata", wb_data_o, 32'h0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55555555;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("late_rvalid_wb", {30'd0, wb_valid_o, done_o}, 32'd0);
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("late_rvalid_quiet", {29'd0, wb_valid_o, done_o, mem_req_o}, 32'd0);
    run_vec(vecs[0]);

    // Back-to-back SW then LW with req_valid held high across DONE.
    @(posedge clk_i); #1;
    drive(1'b1, 3'b010, 32'h3000, 32'h55AA55AA, 5'd0);
    @(negedge clk_i);
    check("b2b_stall0", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check("b2b_sw_req", {30'd0, mem_req_o, mem_we_o}, 32'd3);
    check("b2b_sw_addr", mem_addr_o, 32'h3000);
    check("b2b_sw_wdata", mem_wdata_o, 32'h55AA55AA);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    drive(1'b0, 3'b010, 32'h3008, 32'h0, 5'd9);
    @(negedge clk_i);
    check("b2b_sw_done", {30'd0, done_o, stall_o}, 32'd2);
    check("b2b_done_no_req", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("b2b_lw_accept", {30'd0, stall_o, mem_req_o}, 32'd2);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b1;
    sb_q.push_back('{5'd9, 32'h11223344});
    @(negedge clk_i);
    check("b2b_lw_req", {30'd0, mem_req_o, mem_we_o}, 32'd2);
    check("b2b_lw_addr", mem_addr_o, 32'h3008);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h11223344;
    @(negedge clk_i);
    check("b2b_lw_resp", {30'd0, mem_req_o, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("b2b_lw_done", {30'd0, done_o, wb_valid_o}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      check("b2b_no_dup", {29'd0, mem_req_o, done_o, stall_o}, 32'd0);
    end

    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
